read_resp_assembler: RTL and testbench
======================================

// Module: read_resp_assembler
// PURPOSE
//  Read-return consumer of the read request-ID FIFO. Collects DRAM read-data beats into one line.
//  Pops the matching req ID from the ID FIFO and presents {id, line} to the frontend on valid/ready.
//  Beat input cannot be stalled. Order violations set sticky error flags.
// PARAMETERS
//  BEAT_W     16   width of one DRAM data beat
//  BURST_LEN  8    beats per line (power of 2, >=2)
//  LINE_W     BEAT_W*BURST_LEN   derived, do not override
// PORTS
//  i_clk          in   1       clock
//  i_rst_n        in   1       async active-low reset
//  i_beat_valid   in   1       read-data beat valid (no backpressure)
//  i_beat_data    in   BEAT_W  beat payload; beat 0 first
//  i_id_empty     in   1       ID FIFO empty flag
//  i_id_data      in   req_id_t  ID FIFO head (combinational, valid same cycle)
//  o_id_rd_en     out  1       ID FIFO pop strobe (1-cycle pulse)
//  o_resp_valid   out  1       response valid
//  i_resp_ready   in   1       frontend accepts response
//  o_resp_id      out  req_id_t  response request ID
//  o_resp_data    out  LINE_W  assembled line; beat k at [k*BEAT_W +: BEAT_W]
//  o_resp_parity  out  1       even parity of o_resp_data (see CONFIGURATION)
//  o_err_underflow out 1       sticky: line completed while ID FIFO empty
//  o_err_overflow  out 1       sticky: line completed while response held and not accepted
// BEHAVIOUR
//  Reset (async): beat_cnt=0, collect regs=0, resp FSM=R_IDLE, all outputs 0.
//  Collect: each i_beat_valid stores beat at slot beat_cnt; beat_cnt++ (wraps at BURST_LEN).
//   Beats 0..BURST_LEN-2 are registered. The last beat is merged directly into the response register.
//  Line complete = i_beat_valid && beat_cnt==BURST_LEN-1. This is cycle T.
//  Response FSM: R_IDLE (no response held), R_VALID (o_resp_valid=1).
//   R_IDLE  --line complete--> R_VALID. Response regs are loaded at T; o_resp_valid=1 at T+1.
//   R_VALID --i_resp_ready && !line complete--> R_IDLE.
//   R_VALID --i_resp_ready && line complete--> R_VALID. New line loaded; back-to-back, no bubble.
//   R_VALID --!i_resp_ready && line complete--> R_VALID. Held response unchanged.
//    The new line is dropped; o_err_overflow <= 1.
//  ID pop: o_id_rd_en = line complete && !i_id_empty. Combinational in cycle T.
//   The pop also happens on an overflow drop, so ID/data order stays aligned.
//   o_resp_id loads i_id_data at T.
//  Underflow: line complete && i_id_empty. The response is still delivered, with o_resp_id='0.
//   No pop; o_err_underflow <= 1.
//  Response outputs are held stable while o_resp_valid && !i_resp_ready.
//  Error flags clear only on reset.
//  Reset mid-burst discards partial beats; the next beat after reset is beat 0.
// CONFIGURATION
//  READ_RESP_PARITY_EN defined: o_resp_parity = ^o_resp_data.
//   It is registered alongside o_resp_data, so it is valid in the same cycle.
//  Not defined: o_resp_parity tied 0; no parity logic. Port list is identical in both builds.
// STRUCTURE
//  Shared package frontend_command_definition_pkg owns:
//   req_id_t (5 bit), DRAM_BEAT_W, DRAM_BURST_LEN constants.
//  Optional sub-module read_beat_collector: beat counter, slot registers, line-complete pulse.
//  The response FSM and ID-pop logic stay in the top module.
// TESTING
//  1. IDs 5,6 pushed into the FIFO. Two back-to-back 8-beat bursts 0x0000..0x0007, then 0x0010..0x0017.
//     Ready always high. Expect: id 5 with data 0x0007_..._0000 one cycle after beat 7.
//     Then id 6 with the next line eight cycles later. One o_id_rd_en pulse per line.
//  2. Ready held low after line A (id 3). Expect: outputs stable for 20 cycles.
//     Ready=1 -> one handshake, then o_resp_valid=0.
//  3. Ready low and a second line completes (IDs 3,4 queued). Expect: o_err_overflow=1.
//     Id 4 popped; the held response stays id 3 with its data.
//  4. ID FIFO empty and a burst arrives. Expect: response with id 0, o_err_underflow=1, o_id_rd_en never high.
//  5. Reset asserted after beat 3 of a burst, released, then a full burst of 0xA0..0xA7 (ID 9).
//     Expect: response id 9, data exactly 0xA0..0xA7, no stale beats.
//  6. With READ_RESP_PARITY_EN: line of all 0x0001 beats -> o_resp_parity=0.
//     Beat 0=0x0003, others 0 -> parity=0. Beat 0=0x0001, others 0 -> parity=1.
//     Without the macro, always 0.

Source files
------------

// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command definitions: request ID type, DRAM beat/burst
// geometry and the read-response FSM state encoding.
package frontend_command_definition_pkg;

    localparam int REQ_ID_W       = 5;
    localparam int DRAM_BEAT_W    = 16;
    localparam int DRAM_BURST_LEN = 8;

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef enum logic [0:0] {
        R_IDLE  = 1'b0,
        R_VALID = 1'b1
    } resp_state_e;

endpackage

// File: rtl/read_resp_assembler_if.sv
// Read-return bus: beat input (no backpressure), ID FIFO head/pop and the
// valid/ready response channel toward the frontend. The slave modport is
// the assembler's view; the master modport is the environment's view.
interface read_resp_assembler_if
    import frontend_command_definition_pkg::*;
#(
    parameter int BEAT_W    = DRAM_BEAT_W,
    parameter int BURST_LEN = DRAM_BURST_LEN
) ();

    localparam int LINE_W = BEAT_W * BURST_LEN;

    logic              i_beat_valid;
    logic [BEAT_W-1:0] i_beat_data;
    logic              i_id_empty;
    req_id_t           i_id_data;
    logic              o_id_rd_en;
    logic              o_resp_valid;
    logic              i_resp_ready;
    req_id_t           o_resp_id;
    logic [LINE_W-1:0] o_resp_data;
    logic              o_resp_parity;
    logic              o_err_underflow;
    logic              o_err_overflow;

    modport slave (
        input  i_beat_valid, i_beat_data, i_id_empty, i_id_data, i_resp_ready,
        output o_id_rd_en, o_resp_valid, o_resp_id, o_resp_data, o_resp_parity,
               o_err_underflow, o_err_overflow
    );

    modport master (
        output i_beat_valid, i_beat_data, i_id_empty, i_id_data, i_resp_ready,
        input  o_id_rd_en, o_resp_valid, o_resp_id, o_resp_data, o_resp_parity,
               o_err_underflow, o_err_overflow
    );

endinterface

// File: rtl/read_beat_collector.sv
// Beat collector: counts incoming DRAM beats, registers beats 0..BURST_LEN-2
// into slot registers and flags the cycle in which the last beat arrives.
// The last beat is not stored here; it is passed straight through in the
// assembled line so the response register can capture it in the same cycle.
module read_beat_collector #(
    parameter int BEAT_W    = 16,
    parameter int BURST_LEN = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_beat_valid,
    input  logic [BEAT_W-1:0]           i_beat_data,
    output logic                        o_line_complete,
    output logic [BEAT_W*BURST_LEN-1:0] o_line_data
);

    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0]                 beat_cnt_r;
    logic [BURST_LEN-2:0][BEAT_W-1:0] slots_r;

    // Beat counter: advances on every beat and wraps naturally (power of 2).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (i_beat_valid) begin
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end
    end

    // Slot registers: capture each non-final beat at its position in the line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            slots_r <= '0;
        end else begin
            for (int k = 0; k < BURST_LEN - 1; k++) begin
                if (i_beat_valid && (beat_cnt_r == CNT_W'(k))) begin
                    slots_r[k] <= i_beat_data;
                end
            end
        end
    end

    assign o_line_complete = i_beat_valid && (beat_cnt_r == LAST_SLOT);
    assign o_line_data     = {i_beat_data, slots_r};

endmodule

// File: rtl/read_resp_assembler.sv
// Read response assembler: builds one line from BURST_LEN DRAM beats, pops
// the matching request ID from the ID FIFO and holds {id, line} on a
// valid/ready channel. Lines finishing while a response is still waiting are
// dropped (their ID is still popped to keep ID/data order aligned) and raise
// a sticky overflow flag; lines finishing with no ID available are delivered
// with ID 0 and raise a sticky underflow flag.
// Optional feature macro: READ_RESP_PARITY_EN (registered even parity of the
// response line on o_resp_parity; tied to 0 when undefined).
module read_resp_assembler
    import frontend_command_definition_pkg::*;
#(
    parameter int BEAT_W    = DRAM_BEAT_W,
    parameter int BURST_LEN = DRAM_BURST_LEN
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    read_resp_assembler_if.slave  bus
);

    localparam int LINE_W = BEAT_W * BURST_LEN;

    logic              line_complete_s;
    logic [LINE_W-1:0] line_data_s;
    resp_state_e       state_r;
    resp_state_e       state_next_s;
    logic              resp_valid_s;
    logic              load_s;
    logic              drop_s;
    req_id_t           resp_id_r;
    logic [LINE_W-1:0] resp_data_r;
    logic              err_underflow_r;
    logic              err_overflow_r;

    read_beat_collector #(
        .BEAT_W    (BEAT_W),
        .BURST_LEN (BURST_LEN)
    ) u_collector (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_beat_valid    (bus.i_beat_valid),
        .i_beat_data     (bus.i_beat_data),
        .o_line_complete (line_complete_s),
        .o_line_data     (line_data_s)
    );

    // Response FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= R_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Response FSM next state: a completing line always leaves a response held.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            R_IDLE: begin
                if (line_complete_s) begin
                    state_next_s = R_VALID;
                end else begin
                    state_next_s = R_IDLE;
                end
            end
            R_VALID: begin
                if (line_complete_s) begin
                    state_next_s = R_VALID;
                end else if (bus.i_resp_ready) begin
                    state_next_s = R_IDLE;
                end else begin
                    state_next_s = R_VALID;
                end
            end
            default: state_next_s = R_IDLE;
        endcase
    end

    // Response FSM outputs: valid decode plus load/drop decision for a completing line.
    always_comb begin
        resp_valid_s = 1'b0;
        load_s       = 1'b0;
        drop_s       = 1'b0;
        case (state_r)
            R_IDLE: begin
                load_s = line_complete_s;
            end
            R_VALID: begin
                resp_valid_s = 1'b1;
                if (line_complete_s) begin
                    if (bus.i_resp_ready) begin
                        load_s = 1'b1;
                    end else begin
                        drop_s = 1'b1;
                    end
                end else begin
                    load_s = 1'b0;
                    drop_s = 1'b0;
                end
            end
            default: begin
                resp_valid_s = 1'b0;
            end
        endcase
    end

    // Response payload: captured only when a completing line is accepted into the holding slot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            resp_id_r   <= {REQ_ID_W{1'b0}};
            resp_data_r <= {LINE_W{1'b0}};
        end else if (load_s) begin
            resp_id_r   <= bus.i_id_empty ? {REQ_ID_W{1'b0}} : bus.i_id_data;
            resp_data_r <= line_data_s;
        end
    end

    // Sticky order-violation flags, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_underflow_r <= 1'b0;
            err_overflow_r  <= 1'b0;
        end else begin
            if (line_complete_s && bus.i_id_empty) begin
                err_underflow_r <= 1'b1;
            end
            if (drop_s) begin
                err_overflow_r <= 1'b1;
            end
        end
    end

`ifdef READ_RESP_PARITY_EN
    logic parity_r;

    function automatic logic even_parity(input logic [LINE_W-1:0] data);
        return ^data;
    endfunction

    // Parity register: loaded together with the line so it is valid alongside it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            parity_r <= 1'b0;
        end else if (load_s) begin
            parity_r <= even_parity(line_data_s);
        end
    end

    assign bus.o_resp_parity = parity_r;
`else
    assign bus.o_resp_parity = 1'b0;
`endif

    // The pop also fires on an overflow drop so the next line pairs with the next ID.
    assign bus.o_id_rd_en      = line_complete_s && !bus.i_id_empty;
    assign bus.o_resp_valid    = resp_valid_s;
    assign bus.o_resp_id       = resp_id_r;
    assign bus.o_resp_data     = resp_data_r;
    assign bus.o_err_underflow = err_underflow_r;
    assign bus.o_err_overflow  = err_overflow_r;

endmodule

// File: tb/tb_read_resp_assembler.sv
// Scoreboard bench for read_resp_assembler. The driver feeds beats and keeps
// a reference model (beat list, ID FIFO list, outstanding-response queue);
// a negedge monitor pops and compares whenever the DUT presents a response.
module tb_read_resp_assembler;

    typedef struct {
        logic [4:0]   id;
        logic [127:0] data;
        logic         par;
    } resp_t;

    logic clk;
    logic rst_n;

    read_resp_assembler_if bus_if ();

    read_resp_assembler dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    resp_t       exp_q[$];
    logic [15:0] beats_q[$];
    logic [4:0]  id_fifo[$];
    resp_t       pend_resp;
    bit          pend_valid = 1'b0;
    bit          pend_ovf   = 1'b0;
    bit          pend_unf   = 1'b0;
    bit          exp_ovf    = 1'b0;
    bit          exp_unf    = 1'b0;
    bit          exp_rd_en  = 1'b0;

    function automatic bit exp_parity(input logic [127:0] d);
`ifdef READ_RESP_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Apply what the DUT captured at the edge just passed to the model.
    task automatic commit();
        if (pend_valid) exp_q.push_back(pend_resp);
        pend_valid = 1'b0;
        exp_ovf    = exp_ovf | pend_ovf;
        exp_unf    = exp_unf | pend_unf;
        pend_ovf   = 1'b0;
        pend_unf   = 1'b0;
    endtask

    // One cycle of stimulus; model predicts the outcome of the coming edge.
    task automatic drive(input bit bv, input logic [15:0] bd, input bit rdy);
        resp_t        r;
        logic [127:0] line;
        @(posedge clk);
        #1;
        commit();
        bus_if.i_beat_valid = bv;
        bus_if.i_beat_data  = bd;
        bus_if.i_resp_ready = rdy;
        bus_if.i_id_empty   = (id_fifo.size() == 0);
        bus_if.i_id_data    = (id_fifo.size() == 0) ? 5'($urandom) : id_fifo[0];
        exp_rd_en = 1'b0;
        if (bv) begin
            beats_q.push_back(bd);
            if (beats_q.size() == 8) begin
                line = '0;
                for (int k = 0; k < 8; k++) line[k*16 +: 16] = beats_q[k];
                beats_q.delete();
                r.id = 5'd0;
                if (id_fifo.size() != 0) begin
                    r.id = id_fifo.pop_front();
                    exp_rd_en = 1'b1;
                end else begin
                    pend_unf = 1'b1;
                end
                r.data = line;
                r.par  = exp_parity(line);
                if ((exp_q.size() != 0) && !rdy) begin
                    pend_ovf = 1'b1;
                end else begin
                    pend_resp  = r;
                    pend_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), rdy);
    endtask

    task automatic burst(input logic [15:0] base, input bit rdy);
        for (int k = 0; k < 8; k++) drive(1'b1, base + 16'(k), rdy);
    endtask

    task automatic line_first(input logic [15:0] first, input logic [15:0] rest);
        drive(1'b1, first, 1'b1);
        for (int k = 1; k < 8; k++) drive(1'b1, rest, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_if.i_beat_valid = 1'b0;
        bus_if.i_resp_ready = 1'b0;
        beats_q.delete();
        exp_q.delete();
        pend_valid = 1'b0;
        pend_ovf   = 1'b0;
        pend_unf   = 1'b0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
        exp_rd_en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares outputs against the model, popping on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_valid", bus_if.o_resp_valid, 1'b0);
            check("reset_data", bus_if.o_resp_data, 128'd0);
            check("reset_id", bus_if.o_resp_id, 5'd0);
            check("reset_err_ovf", bus_if.o_err_overflow, 1'b0);
            check("reset_err_unf", bus_if.o_err_underflow, 1'b0);
        end else begin
            check("id_rd_en", bus_if.o_id_rd_en, exp_rd_en);
            check("resp_valid", bus_if.o_resp_valid, exp_q.size() != 0);
            check("err_overflow", bus_if.o_err_overflow, exp_ovf);
            check("err_underflow", bus_if.o_err_underflow, exp_unf);
            if (bus_if.o_resp_valid && (exp_q.size() != 0)) begin
                check("resp_id", bus_if.o_resp_id, exp_q[0].id);
                check("resp_data", bus_if.o_resp_data, exp_q[0].data);
                check("resp_parity", bus_if.o_resp_parity, exp_q[0].par);
                if (bus_if.i_resp_ready) exp_q.delete(0);
            end
        end
    end

    initial begin
        rst_n               = 1'b0;
        bus_if.i_beat_valid = 1'b0;
        bus_if.i_beat_data  = 16'd0;
        bus_if.i_id_empty   = 1'b1;
        bus_if.i_id_data    = 5'd0;
        bus_if.i_resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back bursts, ready high.
        id_fifo.push_back(5'd5);
        id_fifo.push_back(5'd6);
        burst(16'h0000, 1'b1);
        burst(16'h0010, 1'b1);
        idle(3, 1'b1);

        // Response held while ready is low, then one handshake.
        id_fifo.push_back(5'd3);
        burst(16'h0020, 1'b0);
        idle(20, 1'b0);
        idle(4, 1'b1);

        // Second line while held: dropped, ID still popped.
        id_fifo.push_back(5'd3);
        id_fifo.push_back(5'd4);
        burst(16'h0030, 1'b0);
        burst(16'h0040, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // ID FIFO empty: delivered with ID 0.
        burst(16'h0050, 1'b1);
        idle(3, 1'b1);

        // Reset mid-burst discards partial beats.
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h00F0 + 16'(k), 1'b1);
        do_reset();
        id_fifo.push_back(5'd9);
        burst(16'h00A0, 1'b1);
        idle(3, 1'b1);

        // Parity patterns.
        id_fifo.push_back(5'd1);
        id_fifo.push_back(5'd2);
        id_fifo.push_back(5'd7);
        line_first(16'h0001, 16'h0001);
        line_first(16'h0003, 16'h0000);
        line_first(16'h0001, 16'h0000);
        idle(3, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ((id_fifo.size() < 3) && ($urandom_range(0, 3) != 0)) id_fifo.push_back(5'($urandom));
            drive($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
        end

        // Drain with a bounded wait.
        for (int i = 0; (i < 50) && ((exp_q.size() != 0) || pend_valid); i++) idle(1, 1'b1);
        idle(2, 1'b1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
